program_mem_loadable: RTL and testbench

- Parametrised, writable program memory for the MCU core.
- Next generation of the fixed program ROM: same instruction-word role, but width and depth are now parameters and the read is registered.
- Adds a streaming loader, so a host/boot block can download a program image with a valid/ready handshake and a running checksum.
- Sits between the boot/loader logic and the core's instruction fetch stage.

---
 rtl/program_mem_loadable.sv | 141 ++++++++++++++
 tb/tb_program_mem_loadable.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_mem_loadable.sv
// Writable program memory for the MCU core: registered fetch port plus a
// valid/ready streaming loader that keeps a running checksum of the loaded image.
module program_mem_loadable #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int CSUM_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_count,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic [CSUM_W-1:0] checksum
);

    // state | meaning
    // IDLE  | fetches served, waiting for ld_start
    // LOAD  | accepting words; fetches refused so the core stalls on rd_valid
    typedef enum logic {IDLE, LOAD} state_t;

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [CSUM_W-1:0]   csum_q, csum_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic [ADDR_W+1:0]   end_addr;
    logic                range_bad;
    logic                rd_ok;
    logic                rd_in_range;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    // One extra bit so base+count cannot overflow before the bound compare.
    assign end_addr    = {2'b00, ld_base} + {1'b0, ld_count};
    assign range_bad   = end_addr > (ADDR_W+2)'(DEPTH);
    assign rd_in_range = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);
    assign rd_ok       = rd_en && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            csum_q  <= csum_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        csum_d  = csum_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    if (ld_count == '0) begin
                        done_d = 1'b1;
                        csum_d = '0;
                    end else if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        ptr_d   = ld_base;
                        rem_d   = ld_count;
                        csum_d  = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    ptr_d  = ptr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    csum_d = csum_q + CSUM_W'(ld_data);
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_ready = (state_q == LOAD);
        ld_busy  = (state_q == LOAD);
        ld_done  = done_q;
        ld_err   = err_q;
        checksum = csum_q;
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
    end

    // Array has no reset; a reset edge must not complete a pending write.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == LOAD) && ld_valid) begin
            mem[ptr_q[MEM_AW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                rd_data_q <= rd_in_range ? mem[rd_addr[MEM_AW-1:0]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_program_mem_loadable.sv
// Directed bench for program_mem_loadable: default 2048-word instance plus a
// 1024-word instance for the out-of-range fetch case.
module tb_program_mem_loadable;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [13:0] rd_data;
    logic        rd_valid;
    logic        ld_start;
    logic [10:0] ld_base;
    logic [11:0] ld_count;
    logic [13:0] ld_data;
    logic        ld_valid;
    logic        ld_ready, ld_busy, ld_done, ld_err;
    logic [15:0] checksum;

    logic        s_rd_en;
    logic [10:0] s_rd_addr;
    logic [13:0] s_rd_data;
    logic        s_rd_valid;
    logic        s_ld_start;
    logic [10:0] s_ld_base;
    logic [11:0] s_ld_count;
    logic [13:0] s_ld_data;
    logic        s_ld_valid;
    logic        s_ld_ready, s_ld_busy, s_ld_done, s_ld_err;
    logic [15:0] s_checksum;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [13:0] wbuf [16];

    program_mem_loadable u_dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err), .checksum(checksum)
    );

    program_mem_loadable #(.DEPTH(1024)) u_small (
        .clk(clk), .rst(rst),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .ld_start(s_ld_start), .ld_base(s_ld_base), .ld_count(s_ld_count),
        .ld_data(s_ld_data), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready),
        .ld_busy(s_ld_busy), .ld_done(s_ld_done), .ld_err(s_ld_err), .checksum(s_checksum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Load wbuf[0..n-1] at base with ld_valid held high.
    task automatic load_seq(input logic [10:0] base, input int n);
        ld_base  = base;
        ld_count = 12'(n);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = wbuf[i];
            check_val("ld_ready_in_load", {31'd0, ld_ready}, 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        check_val("ld_done_pulse", {31'd0, ld_done}, 32'd1);
        check_val("ld_busy_after", {31'd0, ld_busy}, 32'd0);
        check_val("ld_ready_after", {31'd0, ld_ready}, 32'd0);
        tick();
        check_val("ld_done_clear", {31'd0, ld_done}, 32'd0);
    endtask

    task automatic rd_chk(input logic [10:0] addr, input logic [13:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en = 1'b0;
        check_val("rd_valid", {31'd0, rd_valid}, 32'd1);
        check_val($sformatf("rd_data@%0h", addr), {18'd0, rd_data}, {18'd0, exp});
    endtask

    initial begin
        int pat [6];
        int k;
        int dcnt;
        pat = '{1, 0, 0, 1, 0, 1};

        rst = 1'b1;
        rd_en = 0; rd_addr = 0; ld_start = 0; ld_base = 0; ld_count = 0; ld_data = 0; ld_valid = 0;
        s_rd_en = 0; s_rd_addr = 0; s_ld_start = 0; s_ld_base = 0; s_ld_count = 0; s_ld_data = 0; s_ld_valid = 0;
        tick();
        tick();
        rst = 1'b0;

        check_val("rst_rd_data", {18'd0, rd_data}, 32'd0);
        check_val("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_val("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check_val("rst_ld_busy", {31'd0, ld_busy}, 32'd0);
        check_val("rst_ld_done", {31'd0, ld_done}, 32'd0);
        check_val("rst_ld_err", {31'd0, ld_err}, 32'd0);
        check_val("rst_checksum", {16'd0, checksum}, 32'd0);

        // Seven-word image at base 0
        wbuf[0] = 14'h3000; wbuf[1] = 14'h008D; wbuf[2] = 14'h201A; wbuf[3] = 14'h3008;
        wbuf[4] = 14'h3005; wbuf[5] = 14'h0008; wbuf[6] = 14'h3FFF;
        load_seq(11'h000, 7);
        check_val("csum_img7", {16'd0, checksum}, 32'hF0BB);
        rd_chk(11'h000, 14'h3000); rd_chk(11'h001, 14'h008D); rd_chk(11'h002, 14'h201A);
        rd_chk(11'h003, 14'h3008); rd_chk(11'h004, 14'h3005); rd_chk(11'h005, 14'h0008);
        rd_chk(11'h006, 14'h3FFF);
        tick();
        check_val("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
        check_val("rd_data_hold", {18'd0, rd_data}, 32'h3FFF);

        // Sentinel at 0x0F, then toggled-valid load at 0x10
        wbuf[0] = 14'h1555;
        load_seq(11'h00F, 1);
        wbuf[0] = 14'h0123; wbuf[1] = 14'h2ABC; wbuf[2] = 14'h3F00;
        ld_base = 11'h010; ld_count = 12'd3; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        k = 0; dcnt = 0;
        for (int j = 0; j < 6; j++) begin
            ld_valid = pat[j][0];
            ld_data  = pat[j][0] ? wbuf[k] : 14'h3FFF;
            tick();
            if (pat[j] != 0) k++;
            if (ld_done) dcnt++;
        end
        ld_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (ld_done) dcnt++;
        end
        check_val("toggle_done_count", 32'(dcnt), 32'd1);
        check_val("csum_toggle", {16'd0, checksum}, 32'h6ADF);
        rd_chk(11'h010, 14'h0123); rd_chk(11'h011, 14'h2ABC); rd_chk(11'h012, 14'h3F00);
        rd_chk(11'h00F, 14'h1555);

        // Out-of-range start is rejected; valid words meanwhile are ignored
        wbuf[0] = 14'h0AAA; wbuf[1] = 14'h0BBB;
        load_seq(11'h7FE, 2);
        ld_base = 11'h7FE; ld_count = 12'd3; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check_val("oob_err", {31'd0, ld_err}, 32'd1);
        check_val("oob_busy", {31'd0, ld_busy}, 32'd0);
        ld_valid = 1'b1; ld_data = 14'h3333;
        tick(); tick();
        ld_valid = 1'b0;
        check_val("oob_busy2", {31'd0, ld_busy}, 32'd0);
        check_val("oob_err_sticky", {31'd0, ld_err}, 32'd1);
        rd_chk(11'h7FE, 14'h0AAA); rd_chk(11'h7FF, 14'h0BBB);
        wbuf[0] = 14'h1111; wbuf[1] = 14'h2222;
        ld_base = 11'h7FE; ld_count = 12'd2; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check_val("err_cleared", {31'd0, ld_err}, 32'd0);
        check_val("edge_busy", {31'd0, ld_busy}, 32'd1);
        ld_valid = 1'b1; ld_data = 14'h1111; tick();
        ld_data = 14'h2222; tick();
        ld_valid = 1'b0;
        check_val("edge_done", {31'd0, ld_done}, 32'd1);
        check_val("csum_edge", {16'd0, checksum}, 32'h3333);
        rd_chk(11'h7FE, 14'h1111); rd_chk(11'h7FF, 14'h2222);

        // Zero-count start
        ld_base = 11'h100; ld_count = 12'd0; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check_val("zero_done", {31'd0, ld_done}, 32'd1);
        check_val("zero_busy", {31'd0, ld_busy}, 32'd0);
        check_val("zero_csum", {16'd0, checksum}, 32'd0);
        tick();
        check_val("zero_done_clear", {31'd0, ld_done}, 32'd0);
        check_val("zero_busy2", {31'd0, ld_busy}, 32'd0);

        // Fetch refused while loading
        rd_chk(11'h000, 14'h3000);
        ld_base = 11'h020; ld_count = 12'd2; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        rd_en = 1'b1; rd_addr = 11'h003;
        tick();
        check_val("ld_rd_valid0", {31'd0, rd_valid}, 32'd0);
        check_val("ld_rd_hold0", {18'd0, rd_data}, 32'h3000);
        ld_valid = 1'b1; ld_data = 14'h0005;
        tick();
        check_val("ld_rd_valid1", {31'd0, rd_valid}, 32'd0);
        check_val("ld_rd_hold1", {18'd0, rd_data}, 32'h3000);
        ld_data = 14'h0006;
        tick();
        rd_en = 1'b0; ld_valid = 1'b0;
        check_val("ld_rd_valid2", {31'd0, rd_valid}, 32'd0);
        check_val("ld_rd_hold2", {18'd0, rd_data}, 32'h3000);
        tick();

        // Small instance: in-range and out-of-range fetches
        s_ld_base = 11'h000; s_ld_count = 12'd1; s_ld_start = 1'b1;
        tick();
        s_ld_start = 1'b0; s_ld_valid = 1'b1; s_ld_data = 14'h2AAA;
        tick();
        s_ld_valid = 1'b0;
        s_rd_en = 1'b1; s_rd_addr = 11'h000;
        tick();
        check_val("small_rd0", {18'd0, s_rd_data}, 32'h2AAA);
        s_rd_addr = 11'h7FF;
        tick();
        check_val("small_oob_valid", {31'd0, s_rd_valid}, 32'd1);
        check_val("small_oob_data", {18'd0, s_rd_data}, 32'd0);
        s_rd_addr = 11'h000;
        tick();
        s_rd_addr = 11'h400;
        tick();
        s_rd_en = 1'b0;
        check_val("small_depth_data", {18'd0, s_rd_data}, 32'd0);

        // Reset after 2 of 5 words
        ld_base = 11'h030; ld_count = 12'd5; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 14'h0101; tick();
        ld_data = 14'h0202; tick();
        ld_data = 14'h0303; rst = 1'b1;
        tick();
        rst = 1'b0; ld_valid = 1'b0;
        check_val("mid_rst_busy", {31'd0, ld_busy}, 32'd0);
        check_val("mid_rst_ready", {31'd0, ld_ready}, 32'd0);
        check_val("mid_rst_csum", {16'd0, checksum}, 32'd0);
        check_val("mid_rst_rd_data", {18'd0, rd_data}, 32'd0);
        rd_chk(11'h030, 14'h0101); rd_chk(11'h031, 14'h0202);

        // ld_start while busy is ignored
        ld_base = 11'h040; ld_count = 12'd2; ld_start = 1'b1;
        tick();
        ld_base = 11'h050; ld_count = 12'd1;
        ld_valid = 1'b1; ld_data = 14'h0AAA;
        tick();
        ld_start = 1'b0; ld_data = 14'h0BBB;
        check_val("busy_start_busy", {31'd0, ld_busy}, 32'd1);
        tick();
        ld_valid = 1'b0;
        check_val("busy_start_done", {31'd0, ld_done}, 32'd1);
        check_val("busy_start_csum", {16'd0, checksum}, 32'h1665);
        check_val("busy_start_err", {31'd0, ld_err}, 32'd0);
        rd_chk(11'h040, 14'h0AAA); rd_chk(11'h041, 14'h0BBB);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
